// File: rtl/cpu_pkg.sv
// cpu_pkg: constants and types shared by the CPU register banks.
//   REG_COUNT  - number of architectural registers
//   REG_ADDR_W - width of a register index
//   reg_idx_t  - register index type
//   ZERO_REG   - index of the hard-wired zero register
package cpu_pkg;
    localparam int REG_COUNT  = 32;
    localparam int REG_ADDR_W = 5;

    typedef logic [REG_ADDR_W-1:0] reg_idx_t;

    localparam reg_idx_t ZERO_REG = 5'd0;
endpackage

// File: rtl/reg_read_mux.sv
// reg_read_mux: 32:1 combinational read multiplexer over the register array.
//   i_regs  - register array contents
//   i_raddr - read register index
//   o_rdata - selected register value
module reg_read_mux
    import cpu_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] i_regs [REG_COUNT],
    input  reg_idx_t          i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    assign o_rdata = i_regs[i_raddr];

endmodule

// File: rtl/write_decoder.sv
// write_decoder: turns a write index and write enable into a one-hot
// per-register enable vector. Bit 0 is tied low so the zero register
// can never be written. This module is shared with the CP0 register bank.
//   i_we    - write enable
//   i_waddr - write register index
//   o_wen   - one-hot enable, at most one bit set, bit 0 always 0
module write_decoder
    import cpu_pkg::*;
(
    input  logic                 i_we,
    input  reg_idx_t             i_waddr,
    output logic [REG_COUNT-1:0] o_wen
);

    always_comb begin
        o_wen = '0;
        for (int i = 1; i < REG_COUNT; i++) begin
            o_wen[i] = i_we && (i_waddr == reg_idx_t'(i));
        end
    end

endmodule

// File: rtl/reg_file_demux.sv
// reg_file_demux: 32 x DATA_W general-purpose register file with a one-hot
// write demux, two combinational read ports, optional same-cycle write-to-read
// forwarding, and a registered trace of each committed write.
//   clk, rst_n          - clock, asynchronous active-low reset
//   we, waddr, wdata    - write port
//   raddr1/2, rdata1/2  - combinational read ports
//   wr_done             - one-cycle pulse after each committed write
//   wr_addr_q/wr_data_q - index and data of the last committed write
module reg_file_demux
    import cpu_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int BYPASS = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  reg_idx_t          waddr,
    input  logic [DATA_W-1:0] wdata,
    input  reg_idx_t          raddr1,
    input  reg_idx_t          raddr2,
    output logic [DATA_W-1:0] rdata1,
    output logic [DATA_W-1:0] rdata2,
    output logic              wr_done,
    output reg_idx_t          wr_addr_q,
    output logic [DATA_W-1:0] wr_data_q
);

    logic [DATA_W-1:0]    r_regs [REG_COUNT];
    logic                 r_wr_done;
    reg_idx_t             r_wr_addr;
    logic [DATA_W-1:0]    r_wr_data;

    logic [REG_COUNT-1:0] w_wen;
    logic                 w_commit;
    logic [DATA_W-1:0]    w_mux1;
    logic [DATA_W-1:0]    w_mux2;
    logic                 w_hit1;
    logic                 w_hit2;

    write_decoder u_write_decoder (
        .i_we    (we),
        .i_waddr (waddr),
        .o_wen   (w_wen)
    );

    // w_wen already excludes register 0, so any set bit is a real commit.
    assign w_commit = |w_wen;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            for (int i = 0; i < REG_COUNT; i++) begin
                if (w_wen[i]) begin
                    r_regs[i] <= wdata;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_done <= 1'b0;
            r_wr_addr <= ZERO_REG;
            r_wr_data <= '0;
        end else begin
            r_wr_done <= w_commit;
            if (w_commit) begin
                r_wr_addr <= waddr;
                r_wr_data <= wdata;
            end
        end
    end

    reg_read_mux #(.DATA_W(DATA_W)) u_read_mux1 (
        .i_regs  (r_regs),
        .i_raddr (raddr1),
        .o_rdata (w_mux1)
    );

    reg_read_mux #(.DATA_W(DATA_W)) u_read_mux2 (
        .i_regs  (r_regs),
        .i_raddr (raddr2),
        .o_rdata (w_mux2)
    );

    // The forwarding compare works on addresses only, in parallel with the
    // read mux; its result just picks between wdata and the mux output.
    assign w_hit1 = (BYPASS != 0) && we && (waddr != ZERO_REG) && (waddr == raddr1);
    assign w_hit2 = (BYPASS != 0) && we && (waddr != ZERO_REG) && (waddr == raddr2);

    assign rdata1 = !rst_n ? '0 : (w_hit1 ? wdata : w_mux1);
    assign rdata2 = !rst_n ? '0 : (w_hit2 ? wdata : w_mux2);

    assign wr_done   = r_wr_done;
    assign wr_addr_q = r_wr_addr;
    assign wr_data_q = r_wr_data;

endmodule

// File: tb/tb_reg_file_demux.sv
module tb_reg_file_demux;
    logic        clk;
    logic        rst_n;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [4:0]  raddr1;
    logic [4:0]  raddr2;

    logic [31:0] b_rdata1, b_rdata2, b_wr_data_q;
    logic        b_wr_done;
    logic [4:0]  b_wr_addr_q;
    logic [31:0] n_rdata1, n_rdata2, n_wr_data_q;
    logic        n_wr_done;
    logic [4:0]  n_wr_addr_q;

    int n_tests = 0;
    int n_fail  = 0;

    reg_file_demux #(.DATA_W(32), .BYPASS(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr1(raddr1), .raddr2(raddr2), .rdata1(b_rdata1), .rdata2(b_rdata2),
        .wr_done(b_wr_done), .wr_addr_q(b_wr_addr_q), .wr_data_q(b_wr_data_q)
    );

    reg_file_demux #(.DATA_W(32), .BYPASS(0)) dut_n (
        .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr1(raddr1), .raddr2(raddr2), .rdata1(n_rdata1), .rdata2(n_rdata2),
        .wr_done(n_wr_done), .wr_addr_q(n_wr_addr_q), .wr_data_q(n_wr_data_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        n_tests++;
        if (b_rdata1 !== 32'h0 || b_rdata2 !== 32'h0 || n_rdata1 !== 32'h0 || n_rdata2 !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_rdata: got %h %h %h %h, want 0", b_rdata1, b_rdata2, n_rdata1, n_rdata2);
        end
        n_tests++;
        if (b_wr_done !== 1'b0 || b_wr_addr_q !== 5'd0 || b_wr_data_q !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_trace: got done=%b addr=%0d data=%h, want 0", b_wr_done, b_wr_addr_q, b_wr_data_q);
        end
    endtask

    task automatic test_basic();
        we = 1'b1; waddr = 5'd5; wdata = 32'hDEAD_BEEF; raddr1 = 5'd5; raddr2 = 5'd0;
        step();
        we = 1'b0;
        #1;
        n_tests++;
        if (b_rdata1 !== 32'hDEAD_BEEF || n_rdata1 !== 32'hDEAD_BEEF) begin
            n_fail++;
            $display("FAIL basic_read: got %h / %h, want deadbeef", b_rdata1, n_rdata1);
        end
        n_tests++;
        if (b_wr_done !== 1'b1 || b_wr_addr_q !== 5'd5 || b_wr_data_q !== 32'hDEAD_BEEF) begin
            n_fail++;
            $display("FAIL basic_trace: got done=%b addr=%0d data=%h, want 1 5 deadbeef", b_wr_done, b_wr_addr_q, b_wr_data_q);
        end
        step();
        n_tests++;
        if (b_wr_done !== 1'b0 || b_wr_addr_q !== 5'd5 || n_wr_done !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_pulse: got done=%b/%b addr=%0d, want 0 5", b_wr_done, n_wr_done, b_wr_addr_q);
        end
    endtask

    task automatic test_reg0();
        we = 1'b1; waddr = 5'd0; wdata = 32'hFFFF_FFFF; raddr1 = 5'd0; raddr2 = 5'd0;
        #1;
        n_tests++;
        if (b_rdata1 !== 32'h0 || b_rdata2 !== 32'h0) begin
            n_fail++;
            $display("FAIL reg0_no_bypass: got %h %h, want 0", b_rdata1, b_rdata2);
        end
        step();
        we = 1'b0;
        #1;
        n_tests++;
        if (b_rdata1 !== 32'h0 || n_rdata1 !== 32'h0 || b_wr_done !== 1'b0 || b_wr_addr_q !== 5'd5) begin
            n_fail++;
            $display("FAIL reg0_discard: got rd=%h/%h done=%b addr=%0d, want 0 0 0 5", b_rdata1, n_rdata1, b_wr_done, b_wr_addr_q);
        end
    endtask

    task automatic test_bypass();
        we = 1'b1; waddr = 5'd7; wdata = 32'h1111_1111;
        step();
        we = 1'b1; waddr = 5'd7; wdata = 32'h2222_2222; raddr1 = 5'd7; raddr2 = 5'd7;
        #1;
        n_tests++;
        if (b_rdata1 !== 32'h2222_2222 || b_rdata2 !== 32'h2222_2222) begin
            n_fail++;
            $display("FAIL bypass_on: got %h %h, want 22222222", b_rdata1, b_rdata2);
        end
        n_tests++;
        if (n_rdata1 !== 32'h1111_1111 || n_rdata2 !== 32'h1111_1111) begin
            n_fail++;
            $display("FAIL bypass_off: got %h %h, want 11111111", n_rdata1, n_rdata2);
        end
        raddr2 = 5'd5;
        #1;
        n_tests++;
        if (b_rdata1 !== 32'h2222_2222 || b_rdata2 !== 32'hDEAD_BEEF) begin
            n_fail++;
            $display("FAIL bypass_indep: got %h %h, want 22222222 deadbeef", b_rdata1, b_rdata2);
        end
        step();
        we = 1'b0; raddr2 = 5'd7;
        #1;
        n_tests++;
        if (n_rdata1 !== 32'h2222_2222 || n_rdata2 !== 32'h2222_2222 || b_rdata1 !== 32'h2222_2222) begin
            n_fail++;
            $display("FAIL bypass_after_edge: got %h %h %h, want 22222222", n_rdata1, n_rdata2, b_rdata1);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp;
        step();
        for (int i = 1; i < 32; i++) begin
            we = 1'b1; waddr = 5'(i); wdata = 32'(i) * 32'h0101_0101;
            step();
            n_tests++;
            if (b_wr_done !== 1'b1 || b_wr_addr_q !== 5'(i) || b_wr_data_q !== 32'(i) * 32'h0101_0101) begin
                n_fail++;
                $display("FAIL sweep_trace[%0d]: got done=%b addr=%0d data=%h", i, b_wr_done, b_wr_addr_q, b_wr_data_q);
            end
        end
        we = 1'b0;
        for (int i = 0; i < 32; i++) begin
            raddr1 = 5'(i); raddr2 = 5'(31 - i);
            #1;
            exp = 32'(i) * 32'h0101_0101;
            n_tests++;
            if (b_rdata1 !== exp || n_rdata1 !== exp) begin
                n_fail++;
                $display("FAIL sweep_read[%0d]: got %h / %h, want %h", i, b_rdata1, n_rdata1, exp);
            end
            exp = 32'(31 - i) * 32'h0101_0101;
            n_tests++;
            if (b_rdata2 !== exp) begin
                n_fail++;
                $display("FAIL sweep_read2[%0d]: got %h, want %h", 31 - i, b_rdata2, exp);
            end
        end
        step();
        n_tests++;
        if (b_wr_done !== 1'b0 || b_wr_addr_q !== 5'd31) begin
            n_fail++;
            $display("FAIL sweep_end: got done=%b addr=%0d, want 0 31", b_wr_done, b_wr_addr_q);
        end
    endtask

    task automatic test_reset_mid();
        we = 1'b1; waddr = 5'd9; wdata = 32'h0BAD_F00D;
        step();
        we = 1'b0; raddr1 = 5'd9; raddr2 = 5'd31;
        n_tests++;
        if (b_wr_done !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_reset_done: got %b, want 1", b_wr_done);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (b_rdata1 !== 32'h0 || b_rdata2 !== 32'h0 || n_rdata1 !== 32'h0 || n_rdata2 !== 32'h0) begin
            n_fail++;
            $display("FAIL async_reset_rdata: got %h %h %h %h, want 0", b_rdata1, b_rdata2, n_rdata1, n_rdata2);
        end
        n_tests++;
        if (b_wr_done !== 1'b0 || b_wr_addr_q !== 5'd0 || b_wr_data_q !== 32'h0) begin
            n_fail++;
            $display("FAIL async_reset_trace: got done=%b addr=%0d data=%h, want 0", b_wr_done, b_wr_addr_q, b_wr_data_q);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 32; i++) begin
            raddr1 = 5'(i);
            #1;
            n_tests++;
            if (b_rdata1 !== 32'h0 || n_rdata1 !== 32'h0) begin
                n_fail++;
                $display("FAIL reset_cleared[%0d]: got %h / %h, want 0", i, b_rdata1, n_rdata1);
            end
        end
    endtask

    task automatic test_reset_vs_write();
        step();
        we = 1'b1; waddr = 5'd3; wdata = 32'hAAAA_5555; raddr1 = 5'd3; raddr2 = 5'd3;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (b_rdata1 !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_bypass_suppressed: got %h, want 0", b_rdata1);
        end
        step();
        we = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_tests++;
        if (b_rdata1 !== 32'h0 || n_rdata1 !== 32'h0 || b_wr_done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_wins: got rd=%h/%h done=%b, want 0 0 0", b_rdata1, n_rdata1, b_wr_done);
        end
        step();
        n_tests++;
        if (b_wr_done !== 1'b0 || n_rdata1 !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_wins_later: got done=%b rd=%h, want 0 0", b_wr_done, n_rdata1);
        end
        // First write after release commits on the first edge.
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1; we = 1'b1; waddr = 5'd3; wdata = 32'h0000_0055;
        step();
        we = 1'b0;
        #1;
        n_tests++;
        if (n_rdata1 !== 32'h0000_0055 || b_wr_done !== 1'b1 || b_wr_addr_q !== 5'd3) begin
            n_fail++;
            $display("FAIL first_write_after_reset: got rd=%h done=%b addr=%0d, want 55 1 3", n_rdata1, b_wr_done, b_wr_addr_q);
        end
    endtask

    initial begin
        rst_n = 1'b0; we = 1'b0; waddr = 5'd0; wdata = 32'h0; raddr1 = 5'd0; raddr2 = 5'd0;
        step();
        test_reset();
        @(negedge clk);
        rst_n = 1'b1;
        step();
        test_basic();
        test_reg0();
        test_bypass();
        test_back_to_back();
        test_reset_mid();
        test_reset_vs_write();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
